// File: rtl/jtag_axi_txn_ctrl.sv
// JTAG DR to bus request sequencer: one start pulse becomes one valid/ready transaction plus captured status/read data.
// Latency: req_valid rises 1 tck after start; status/data_rd update on the edge that completes the response.
// Backpressure: request held stable until req_ready; response awaited with resp_ready; optional timeout aborts either phase.
module jtag_axi_txn_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        tck,
  input  logic        trstn,
  input  logic        start,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic        cmd_auto_inc,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        status_clear,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  output logic [1:0]  req_size,
  output logic        req_abort,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_rdata,
  input  logic [1:0]  resp_err,
  output logic        busy,
  output logic [2:0]  status,
  output logic        overrun,
  output logic [31:0] data_rd,
  output logic [31:0] cur_addr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TO_M1 = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_RUNNING = 3'b001;
  localparam logic [2:0] ST_OK      = 3'b010;
  localparam logic [2:0] ST_SLVERR  = 3'b011;
  localparam logic [2:0] ST_DECERR  = 3'b100;
  localparam logic [2:0] ST_TIMEOUT = 3'b101;
  localparam logic [2:0] ST_BADCMD  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        auto_inc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  state_t       state, state_nxt;
  cmd_t         cmd, cmd_new;
  logic [CNT_W-1:0] cnt;
  logic [31:0]  ea;
  logic [3:0]   strb;
  logic [31:0]  rd_shift, rd_data;
  logic         bad_cmd, launch, reject, clear;
  logic         req_hs, resp_hs, tmo_hit;

  always_comb begin
    ea = cmd_auto_inc ? cur_addr : cmd_addr;
    bad_cmd = (cmd_size == 2'd3) ||
              (cmd_size == 2'd1 && ea[0]) ||
              (cmd_size == 2'd2 && ea[1:0] != 2'b00);
    case (cmd_size)
      2'd0:    strb = 4'b0001 << ea[1:0];
      2'd1:    strb = 4'b0011 << ea[1:0];
      default: strb = 4'b1111;
    endcase
    cmd_new.write    = cmd_write;
    cmd_new.size     = cmd_size;
    cmd_new.auto_inc = cmd_auto_inc;
    cmd_new.addr     = ea;
    cmd_new.wdata    = cmd_wdata << {ea[1:0], 3'b000};
    cmd_new.wstrb    = cmd_write ? strb : 4'b0000;
  end

  // Read data arrives on its bus lanes; bring it down to bit 0 and trim to size.
  always_comb begin
    rd_shift = resp_rdata >> {cmd.addr[1:0], 3'b000};
    case (cmd.size)
      2'd0:    rd_data = {24'h0, rd_shift[7:0]};
      2'd1:    rd_data = {16'h0, rd_shift[15:0]};
      default: rd_data = rd_shift;
    endcase
  end

  assign busy       = (state == S_REQ) || (state == S_RESP);
  assign req_valid  = (state == S_REQ);
  assign resp_ready = (state == S_RESP);
  assign req_hs     = req_valid && req_ready;
  assign resp_hs    = resp_ready && resp_valid;
  // A handshake landing on the final counted cycle takes priority over the abort.
  assign tmo_hit    = TO_EN && busy && (cnt == TO_M1) && !req_hs && !resp_hs;

  assign req_write  = cmd.write;
  assign req_addr   = cmd.addr;
  assign req_wdata  = cmd.wdata;
  assign req_wstrb  = cmd.wstrb;
  assign req_size   = cmd.size;

  always_ff @(posedge tck) begin
    if (!trstn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    reject    = 1'b0;
    clear     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (bad_cmd) begin
            reject    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            launch    = 1'b1;
            state_nxt = S_REQ;
          end
        end else if (status_clear) begin
          clear     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (req_ready)    state_nxt = S_RESP;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      S_RESP: begin
        if (resp_valid)   state_nxt = S_DONE;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tck) begin
    if (!trstn) begin
      cmd       <= '0;
      cnt       <= '0;
      status    <= ST_IDLE;
      overrun   <= 1'b0;
      data_rd   <= '0;
      cur_addr  <= '0;
      req_abort <= 1'b0;
    end else begin
      req_abort <= tmo_hit;
      if (launch) begin
        cmd      <= cmd_new;
        cnt      <= '0;
        status   <= ST_RUNNING;
        cur_addr <= ea;
      end else if (busy && cnt != TO_M1) begin
        cnt <= cnt + 1'b1;
      end
      if (reject)  status <= ST_BADCMD;
      if (clear)   status <= ST_IDLE;
      if (tmo_hit) status <= ST_TIMEOUT;
      if (resp_hs) begin
        if (!resp_err[1]) begin
          status <= ST_OK;
          if (!cmd.write)   data_rd  <= rd_data;
          if (cmd.auto_inc) cur_addr <= cur_addr + (32'd1 << cmd.size);
        end else begin
          status <= resp_err[0] ? ST_DECERR : ST_SLVERR;
        end
      end
      if (status_clear && !busy) overrun <= 1'b0;
      else if (start && busy)    overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_axi_txn_ctrl.sv
// Bench for jtag_axi_txn_ctrl: request scoreboard plus per-scenario status/data checks.
module tb_jtag_axi_txn_ctrl;

  localparam int TO = 8;

  logic        tck = 1'b0;
  logic        trstn = 1'b0;
  logic        start = 1'b0;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_size = 2'd0;
  logic        cmd_auto_inc = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        status_clear = 1'b0;
  logic        req_valid, req_write, req_abort, resp_ready, busy, overrun;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr, req_wdata, data_rd, cur_addr;
  logic [3:0]  req_wstrb;
  logic [1:0]  req_size;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic [1:0]  resp_err = 2'b00;
  logic [2:0]  status;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t exp_q[$];
  req_t sb_exp, sb_got;

  jtag_axi_txn_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .tck(tck), .trstn(trstn), .start(start), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_auto_inc(cmd_auto_inc), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .status_clear(status_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_size(req_size), .req_abort(req_abort),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .status(status), .overrun(overrun),
    .data_rd(data_rd), .cur_addr(cur_addr)
  );

  always #5 tck = ~tck;

  // Requests that will be accepted on the next rising edge are scored mid-cycle.
  always @(negedge tck) begin
    if (trstn && req_valid && req_ready) begin
      sb_got = '{write: req_write, size: req_size, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_req: got addr %h write %0b, required no request", req_addr, req_write);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_req: got w=%0b sz=%0d addr=%h wdata=%h wstrb=%h, required w=%0b sz=%0d addr=%h wdata=%h wstrb=%h",
                   sb_got.write, sb_got.size, sb_got.addr, sb_got.wdata, sb_got.wstrb,
                   sb_exp.write, sb_exp.size, sb_exp.addr, sb_exp.wdata, sb_exp.wstrb);
        end
      end
    end
  end

  task automatic tick;
    @(posedge tck);
    #1;
  endtask

  task automatic expect_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
    exp_q.push_back('{write: w, size: sz, addr: a, wdata: wd, wstrb: ws});
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic ai,
                       input logic [31:0] a, input logic [31:0] wd);
    start = 1'b1; cmd_write = w; cmd_size = sz; cmd_auto_inc = ai; cmd_addr = a; cmd_wdata = wd;
    tick;
    start = 1'b0;
  endtask

  // Accepts the pending request, waits resp_dly cycles in the response phase, then answers.
  task automatic run_bus(input int resp_dly, input logic [31:0] rdata, input logic [1:0] err);
    bit seen;
    seen = 1'b0;
    req_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (req_valid) seen = 1'b1;
      tick;
    end
    req_ready = 1'b0;
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL req_handshake: got no req_valid within 20 cycles, required req_valid"); end
    for (int i = 0; i < 20 && !resp_ready; i++) tick;
    n_tests++;
    if (resp_ready !== 1'b1) begin n_fail++; $display("FAIL resp_ready_wait: got %b, required 1", resp_ready); end
    repeat (resp_dly) tick;
    resp_valid = 1'b1; resp_rdata = rdata; resp_err = err;
    tick;
    resp_valid = 1'b0; resp_rdata = '0; resp_err = 2'b00;
  endtask

  task automatic test_reset;
    trstn = 1'b0;
    repeat (2) tick;
    n_tests++;
    if ({req_valid, resp_ready, req_abort, busy, overrun, status} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, required 00000000", {req_valid, resp_ready, req_abort, busy, overrun, status});
    end
    n_tests++;
    if ({data_rd, cur_addr, req_addr, req_wdata, req_wstrb} !== '0) begin
      n_fail++; $display("FAIL reset_data: got data_rd %h cur_addr %h req_addr %h, required all 0", data_rd, cur_addr, req_addr);
    end
    trstn = 1'b1;
    tick;
  endtask

  task automatic test_word_write;
    expect_req(1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
    n_tests++;
    if ({req_valid, busy, status} !== {2'b11, 3'b001}) begin
      n_fail++; $display("FAIL ww_issue: got valid/busy/status %b, required 11001", {req_valid, busy, status});
    end
    run_bus(3, 32'hFFFF_FFFF, 2'b00);
    n_tests++;
    if ({busy, req_valid, status} !== {2'b00, 3'b010}) begin
      n_fail++; $display("FAIL ww_done: got busy/valid/status %b, required 00010", {busy, req_valid, status});
    end
    n_tests++;
    if (data_rd !== 32'h0 || cur_addr !== 32'h0000_1000) begin
      n_fail++; $display("FAIL ww_regs: got data_rd %h cur_addr %h, required 00000000 00001000", data_rd, cur_addr);
    end
  endtask

  task automatic test_lanes;
    expect_req(1'b0, 2'd0, 32'h0000_2003, 32'h0, 4'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h0);
    run_bus(1, 32'hAB00_0000, 2'b00);
    n_tests++;
    if (data_rd !== 32'h0000_00AB || status !== 3'b010) begin
      n_fail++; $display("FAIL byte_read: got data_rd %h status %b, required 000000ab 010", data_rd, status);
    end
    expect_req(1'b0, 2'd1, 32'h0000_2002, 32'h0, 4'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0);
    run_bus(0, 32'h1234_ABCD, 2'b01);
    n_tests++;
    if (data_rd !== 32'h0000_1234 || status !== 3'b010) begin
      n_fail++; $display("FAIL half_read_exokay: got data_rd %h status %b, required 00001234 010", data_rd, status);
    end
    expect_req(1'b1, 2'd1, 32'h0000_2002, 32'hBEEF_0000, 4'hC);
    issue(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    run_bus(0, 32'h0, 2'b00);
    expect_req(1'b1, 2'd0, 32'h0000_2001, 32'h0000_5A00, 4'h2);
    issue(1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h0000_005A);
    run_bus(0, 32'h0, 2'b00);
    n_tests++;
    if (data_rd !== 32'h0000_1234) begin
      n_fail++; $display("FAIL write_keeps_data_rd: got %h, required 00001234", data_rd);
    end
  endtask

  task automatic test_auto_inc;
    logic [31:0] exp_addr [4] = '{32'h0FFF_FFFC, 32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0004};
    logic [31:0] exp_cur  [4] = '{32'h0FFF_FFFC, 32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
    for (int i = 0; i < 4; i++) begin
      expect_req(1'b0, 2'd2, exp_addr[i], 32'h0, 4'h0);
      issue(1'b0, 2'd2, (i != 0), (i == 0) ? 32'h0FFF_FFFC : 32'hDEAD_0001, 32'h0);
      run_bus(0, 32'h1111_1111 * (i + 1), 2'b00);
      n_tests++;
      if (cur_addr !== exp_cur[i] || data_rd !== 32'h1111_1111 * (i + 1)) begin
        n_fail++; $display("FAIL auto_inc_%0d: got cur_addr %h data_rd %h, required %h %h", i, cur_addr, data_rd, exp_cur[i], 32'h1111_1111 * (i + 1));
      end
    end
    expect_req(1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0, 4'h0);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0);
    run_bus(0, 32'h0000_0055, 2'b00);
    expect_req(1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0, 4'h0);
    issue(1'b0, 2'd2, 1'b1, 32'h0000_0000, 32'h0);
    run_bus(0, 32'h0000_0066, 2'b00);
    n_tests++;
    if (cur_addr !== 32'h0000_0000) begin
      n_fail++; $display("FAIL auto_inc_wrap: got cur_addr %h, required 00000000", cur_addr);
    end
  endtask

  task automatic test_errors;
    issue(1'b0, 2'd3, 1'b0, 32'h0000_4000, 32'h0);
    n_tests++;
    if ({req_valid, busy, status} !== {2'b00, 3'b110}) begin
      n_fail++; $display("FAIL bad_size: got valid/busy/status %b, required 00110", {req_valid, busy, status});
    end
    tick;
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0);
    tick;
    n_tests++;
    if ({req_valid, busy, status} !== {2'b00, 3'b110} || cur_addr !== 32'h0) begin
      n_fail++; $display("FAIL bad_align: got valid/busy/status %b cur_addr %h, required 00110 00000000", {req_valid, busy, status}, cur_addr);
    end
    expect_req(1'b0, 2'd2, 32'h0000_6000, 32'h0, 4'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0);
    run_bus(0, 32'h0000_0077, 2'b00);
    expect_req(1'b0, 2'd2, 32'h0000_6000, 32'h0, 4'h0);
    issue(1'b0, 2'd2, 1'b1, 32'h0000_0000, 32'h0);
    run_bus(2, 32'hCAFE_CAFE, 2'b10);
    n_tests++;
    if (status !== 3'b011 || data_rd !== 32'h0000_0077 || cur_addr !== 32'h0000_6000) begin
      n_fail++; $display("FAIL slverr: got status %b data_rd %h cur_addr %h, required 011 00000077 00006000", status, data_rd, cur_addr);
    end
    expect_req(1'b0, 2'd2, 32'h0000_5000, 32'h0, 4'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
    run_bus(0, 32'hFFFF_FFFF, 2'b11);
    n_tests++;
    if (status !== 3'b100 || data_rd !== 32'h0000_0077) begin
      n_fail++; $display("FAIL decerr: got status %b data_rd %h, required 100 00000077", status, data_rd);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    ok = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0);
    for (int k = 1; k < TO; k++) begin
      tick;
      if (req_abort !== 1'b0 || req_valid !== 1'b1) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL tmo_early: got early abort or dropped req_valid, required valid held %0d cycles", TO); end
    tick;
    n_tests++;
    if ({req_abort, req_valid, busy, status} !== {3'b100, 3'b101}) begin
      n_fail++; $display("FAIL tmo_abort: got abort/valid/busy/status %b, required 100101", {req_abort, req_valid, busy, status});
    end
    tick;
    n_tests++;
    if (req_abort !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got %b, required 0", req_abort); end

    expect_req(1'b0, 2'd2, 32'h0000_3004, 32'h0, 4'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_3004, 32'h0);
    repeat (TO - 1) tick;
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    n_tests++;
    if ({req_abort, resp_ready, busy} !== 3'b011) begin
      n_fail++; $display("FAIL tmo_late_hs: got abort/resp_ready/busy %b, required 011", {req_abort, resp_ready, busy});
    end
    resp_valid = 1'b1; resp_rdata = 32'h0000_3333;
    tick;
    resp_valid = 1'b0;
    n_tests++;
    if (status !== 3'b010 || data_rd !== 32'h0000_3333 || req_abort !== 1'b0) begin
      n_fail++; $display("FAIL tmo_late_done: got status %b data_rd %h abort %b, required 010 00003333 0", status, data_rd, req_abort);
    end
  endtask

  task automatic test_overrun;
    expect_req(1'b0, 2'd2, 32'h0000_7000, 32'h0, 4'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_8000, 32'h0000_0099);
    n_tests++;
    if ({overrun, busy, resp_ready, req_valid} !== 4'b1110) begin
      n_fail++; $display("FAIL overrun_set: got overrun/busy/resp_ready/valid %b, required 1110", {overrun, busy, resp_ready, req_valid});
    end
    resp_valid = 1'b1; resp_rdata = 32'h0000_0777;
    tick;
    resp_valid = 1'b0;
    n_tests++;
    if (status !== 3'b010 || overrun !== 1'b1 || cur_addr !== 32'h0000_7000 || data_rd !== 32'h0000_0777) begin
      n_fail++; $display("FAIL overrun_done: got status %b overrun %b cur_addr %h data_rd %h, required 010 1 00007000 00000777", status, overrun, cur_addr, data_rd);
    end
    status_clear = 1'b1;
    tick;
    status_clear = 1'b0;
    n_tests++;
    if (status !== 3'b000 || overrun !== 1'b0 || data_rd !== 32'h0000_0777 || cur_addr !== 32'h0000_7000) begin
      n_fail++; $display("FAIL status_clear: got status %b overrun %b data_rd %h cur_addr %h, required 000 0 00000777 00007000", status, overrun, data_rd, cur_addr);
    end
  endtask

  task automatic test_reset_mid;
    expect_req(1'b1, 2'd2, 32'h0000_9000, 32'h1234_5678, 4'hF);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_9000, 32'h1234_5678);
    n_tests++;
    if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got req_valid %b, required 1", req_valid); end
    trstn = 1'b0;
    tick;
    n_tests++;
    if ({req_valid, resp_ready, req_abort, busy, overrun, status, req_write, req_wstrb} !== '0 ||
        {req_addr, req_wdata, data_rd, cur_addr} !== '0) begin
      n_fail++; $display("FAIL rst_mid: got valid %b abort %b status %b req_addr %h data_rd %h cur_addr %h, required all 0",
                         req_valid, req_abort, status, req_addr, data_rd, cur_addr);
    end
    exp_q.delete();
    trstn = 1'b1;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_write();
    test_lanes();
    test_auto_inc();
    test_errors();
    test_timeout();
    test_overrun();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d requests still expected, required 0", exp_q.size());
    end
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
